// File: rtl/aes_decrypt_sequencer.sv
// ============================================================================
// aes_decrypt_sequencer : control FSM for the shared AES-128 inverse cipher
// Revision 1.0
// ============================================================================
`default_nettype none

module aes_decrypt_sequencer #(
  parameter int KEY_EXP_CYCLES = 11,
  parameter int NUM_ROUNDS     = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       KEY_EXP_EN,
  output logic       STATE_WE,
  output logic [2:0] STATE_OP,
  output logic [3:0] ROUND_IDX,
  output logic [1:0] COL_SEL
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_KEYEXP  = 4'd2,
    S_ARK0    = 4'd3,
    S_RND_ISR = 4'd4,
    S_RND_ISB = 4'd5,
    S_RND_ARK = 4'd6,
    S_RND_IMC = 4'd7,
    S_FIN_ISR = 4'd8,
    S_FIN_ISB = 4'd9,
    S_FIN_ARK = 4'd10,
    S_DONE    = 4'd11
  } state_t;

  localparam logic [5:0] c_kexp_last = 6'(KEY_EXP_CYCLES - 1);
  localparam logic [3:0] c_num_rnd   = 4'(NUM_ROUNDS);
  localparam logic [3:0] c_last_rnd  = 4'(NUM_ROUNDS - 1);

  localparam logic [2:0] c_op_nop  = 3'd0;
  localparam logic [2:0] c_op_load = 3'd1;
  localparam logic [2:0] c_op_ark  = 3'd2;
  localparam logic [2:0] c_op_isr  = 3'd3;
  localparam logic [2:0] c_op_isb  = 3'd4;
  localparam logic [2:0] c_op_imc  = 3'd5;

  state_t     state_q, state_d;
  logic [5:0] kcnt_q, kcnt_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] col_q, col_d;

  logic       done_d, busy_d, kexp_d, we_d;
  logic [2:0] op_d;
  logic [3:0] idx_d;
  logic [1:0] colsel_d;

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    rnd_d   = rnd_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (AES_START) begin
          state_d = S_LOAD;
          kcnt_d  = 6'd0;
          rnd_d   = 4'd0;
          col_d   = 2'd0;
        end
      end
      S_LOAD: begin
        state_d = S_KEYEXP;
        kcnt_d  = 6'd0;
      end
      S_KEYEXP: begin
        if (kcnt_q == c_kexp_last) begin
          state_d = S_ARK0;
          rnd_d   = 4'd1;
        end else begin
          kcnt_d = kcnt_q + 6'd1;
        end
      end
      S_ARK0:    state_d = S_RND_ISR;
      S_RND_ISR: state_d = S_RND_ISB;
      S_RND_ISB: state_d = S_RND_ARK;
      S_RND_ARK: begin
        state_d = S_RND_IMC;
        col_d   = 2'd0;
      end
      S_RND_IMC: begin
        if (col_q == 2'd3) begin
          if (rnd_q < c_last_rnd) begin
            state_d = S_RND_ISR;
            rnd_d   = rnd_q + 4'd1;
          end else begin
            state_d = S_FIN_ISR;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      S_FIN_ISR: state_d = S_FIN_ISB;
      S_FIN_ISB: state_d = S_FIN_ARK;
      S_FIN_ARK: state_d = S_DONE;
      S_DONE: begin
        if (!AES_START) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    done_d   = 1'b0;
    busy_d   = 1'b1;
    kexp_d   = 1'b0;
    we_d     = 1'b1;
    op_d     = c_op_nop;
    idx_d    = 4'd0;
    colsel_d = 2'd0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
        we_d   = 1'b0;
      end
      S_LOAD:    op_d = c_op_load;
      S_KEYEXP: begin
        kexp_d = 1'b1;
        we_d   = 1'b0;
      end
      S_ARK0: begin
        op_d  = c_op_ark;
        idx_d = c_num_rnd;
      end
      S_RND_ISR: op_d = c_op_isr;
      S_RND_ISB: op_d = c_op_isb;
      S_RND_ARK: begin
        op_d  = c_op_ark;
        idx_d = c_num_rnd - rnd_d;
      end
      S_RND_IMC: begin
        op_d     = c_op_imc;
        colsel_d = col_d;
      end
      S_FIN_ISR: op_d = c_op_isr;
      S_FIN_ISB: op_d = c_op_isb;
      S_FIN_ARK: op_d = c_op_ark;
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        we_d   = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        we_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      kcnt_q     <= 6'd0;
      rnd_q      <= 4'd0;
      col_q      <= 2'd0;
      AES_DONE   <= 1'b0;
      BUSY       <= 1'b0;
      KEY_EXP_EN <= 1'b0;
      STATE_WE   <= 1'b0;
      STATE_OP   <= 3'd0;
      ROUND_IDX  <= 4'd0;
      COL_SEL    <= 2'd0;
    end else begin
      state_q    <= state_d;
      kcnt_q     <= kcnt_d;
      rnd_q      <= rnd_d;
      col_q      <= col_d;
      AES_DONE   <= done_d;
      BUSY       <= busy_d;
      KEY_EXP_EN <= kexp_d;
      STATE_WE   <= we_d;
      STATE_OP   <= op_d;
      ROUND_IDX  <= idx_d;
      COL_SEL    <= colsel_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_sequencer.sv
// ============================================================================
// tb_aes_decrypt_sequencer : scoreboard bench for the AES decrypt sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_aes_decrypt_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       kexp;
    logic       we;
    logic [2:0] op;
    logic [3:0] idx;
    logic [1:0] col;
  } obs_t;

  typedef struct {
    int which;      // 0: default parameters, 1: KEY_EXP_CYCLES=1, NUM_ROUNDS=2
    int hold;       // cycles AES_START stays high
    int done_len;
    int done_edge;
    int we_cnt;
    int imc_cnt;
    int kexp_cnt;
    int abort_at;   // cycle at which RESET is pulsed, -1 for none
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;
  logic start_def, start_sml;

  logic       d_done, d_busy, d_kexp, d_we;
  logic [2:0] d_op;
  logic [3:0] d_idx;
  logic [1:0] d_col;
  logic       s_done, s_busy, s_kexp, s_we;
  logic [2:0] s_op;
  logic [3:0] s_idx;
  logic [1:0] s_col;

  obs_t obs_def, obs_sml;
  assign obs_def = {d_busy, d_done, d_kexp, d_we, d_op, d_idx, d_col};
  assign obs_sml = {s_busy, s_done, s_kexp, s_we, s_op, s_idx, s_col};

  always #5 CLK = ~CLK;

  aes_decrypt_sequencer dut (
    .CLK(CLK), .RESET(RESET), .AES_START(start_def),
    .AES_DONE(d_done), .BUSY(d_busy), .KEY_EXP_EN(d_kexp), .STATE_WE(d_we),
    .STATE_OP(d_op), .ROUND_IDX(d_idx), .COL_SEL(d_col)
  );

  aes_decrypt_sequencer #(.KEY_EXP_CYCLES(1), .NUM_ROUNDS(2)) dut_sml (
    .CLK(CLK), .RESET(RESET), .AES_START(start_sml),
    .AES_DONE(s_done), .BUSY(s_busy), .KEY_EXP_EN(s_kexp), .STATE_WE(s_we),
    .STATE_OP(s_op), .ROUND_IDX(s_idx), .COL_SEL(s_col)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic obs_t mk(input logic busy, input logic done, input logic kexp,
                              input logic we, input int op, input int idx, input int col);
    obs_t m;
    m.busy = busy;
    m.done = done;
    m.kexp = kexp;
    m.we   = we;
    m.op   = 3'(op);
    m.idx  = 4'(idx);
    m.col  = 2'(col);
    return m;
  endfunction

  // Expected cycle-by-cycle trace of one decryption, cycle 0 being LOAD.
  task automatic build_trace(input int k, input int n);
    exp_q.push_back(mk(1, 0, 0, 1, 1, 0, 0));
    repeat (k) exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 1, 2, n, 0));
    for (int r = 1; r < n; r++) begin
      exp_q.push_back(mk(1, 0, 0, 1, 3, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 1, 4, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 1, 2, n - r, 0));
      for (int c = 0; c < 4; c++) exp_q.push_back(mk(1, 0, 0, 1, 5, 0, c));
    end
    exp_q.push_back(mk(1, 0, 0, 1, 3, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 1, 4, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 1, 2, 0, 0));
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_def = v;
    else start_sml = v;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int   k, n, total, we_n, imc_n, kexp_n, loads, first_done;
    obs_t o, e;
    k = (v.which == 0) ? 11 : 1;
    n = (v.which == 0) ? 10 : 2;
    exp_q.delete();
    build_trace(k, n);
    repeat (v.done_len) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    repeat (3) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    total = exp_q.size();
    we_n = 0; imc_n = 0; kexp_n = 0; loads = 0; first_done = -1;
    set_start(v.which, 1'b1);
    for (int c = 0; c < total; c++) begin
      @(posedge CLK);
      #1;
      o = (v.which == 0) ? obs_def : obs_sml;
      e = exp_q.pop_front();
      check($sformatf("vec%0d cycle%0d", id, c), 32'(o), 32'(e));
      if (o.we) we_n++;
      if (o.op == 3'd5) imc_n++;
      if (o.kexp) kexp_n++;
      if (o.op == 3'd1) loads++;
      if (o.done && first_done < 0) first_done = c;
      if (c == v.hold - 1) set_start(v.which, 1'b0);
      if (c == v.abort_at) begin
        set_start(v.which, 1'b0);
        #3 RESET = 1'b1;
        #1 check($sformatf("vec%0d async reset outputs", id), 32'(obs_def), 32'd0);
        @(posedge CLK);
        #1 check($sformatf("vec%0d reset held outputs", id), 32'(obs_def), 32'd0);
        #3 RESET = 1'b0;
        return;
      end
    end
    check($sformatf("vec%0d done edge", id), 32'(first_done), 32'(v.done_edge));
    check($sformatf("vec%0d STATE_WE cycles", id), 32'(we_n), 32'(v.we_cnt));
    check($sformatf("vec%0d IMC cycles", id), 32'(imc_n), 32'(v.imc_cnt));
    check($sformatf("vec%0d KEY_EXP_EN cycles", id), 32'(kexp_n), 32'(v.kexp_cnt));
    check($sformatf("vec%0d LOAD count", id), 32'(loads), 32'd1);
  endtask

  initial begin
    //          which hold done_len done_edge we  imc kexp abort
    vecs[0] = '{0,   1,   1,       79,       68, 36, 11,  -1};
    vecs[1] = '{0,   200, 121,     79,       68, 36, 11,  -1};
    vecs[2] = '{0,   30,  1,       79,       68, 36, 11,  -1};
    vecs[3] = '{0,   1,   1,       79,       68, 36, 11,  45};
    vecs[4] = '{0,   1,   1,       79,       68, 36, 11,  -1};
    vecs[5] = '{1,   1,   1,       13,       12, 4,  1,   -1};
    vecs[6] = '{1,   20,  7,       13,       12, 4,  1,   -1};

    RESET     = 1'b1;
    start_def = 1'b0;
    start_sml = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset state default", 32'(obs_def), 32'd0);
    check("reset state small", 32'(obs_sml), 32'd0);
    #3 RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("idle after reset", 32'(obs_def), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
